// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared definitions for the NPC memory-port arbiter: FSM states,
// owner identifiers and the wait-counter width.
package ysyx_24100005_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Owner ids double as the index of the requester in the req/gnt vectors.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT in 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// Combinational two-way round-robin picker. Bit 0 is the IFU, bit 1 the LSU.
// On a tie the requester that did not win last time is chosen; a lone
// requester always wins.
module ysyx_24100005_rr_arb2
    import ysyx_24100005_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick a one-hot winner from the request vector and the last owner.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            if (last == OWN_LSU) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares the single NPC memory port between instruction fetch and load/store.
// One request is accepted at a time, the port is held for MEM_LAT cycles and
// a one-cycle response is returned to the requester that won the grant.
//
// Handshake: a requester raises *_valid with a stable payload; the request is
// taken in the cycle where *_valid and *_ready are both high. *_ready is only
// ever high in IDLE (and never during reset), so at most one request is
// accepted per transaction. Responses have no backpressure.
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1     // legal range 1..15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_valid,
    output logic                ifu_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_valid,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                owner;
    logic                last;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [1:0]          gnt;
    logic                grant_ok;

    ysyx_24100005_rr_arb2 u_arb (
        .req  ({lsu_valid, ifu_valid}),
        .last (last),
        .gnt  (gnt)
    );

    // Grants are only visible in IDLE and never while reset is held.
    assign grant_ok  = (state == ST_IDLE) && rst;
    assign ifu_ready = grant_ok && gnt[0];
    assign lsu_ready = grant_ok && gnt[1];

    // Memory port is driven from the latched request; the write strobe is
    // confined to the last WAIT cycle so a write lands exactly once.
    assign mem_valid = (state == ST_WAIT);
    assign mem_wen   = (state == ST_WAIT) && wen_q && (cnt == '0);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    assign ifu_resp_valid = (state == ST_RESP) && (owner == OWN_IFU);
    assign lsu_resp_valid = (state == ST_RESP) && (owner == OWN_LSU);

    assign dbg_state = state;

    // Controller: grant and latch in IDLE, count in WAIT, respond in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner     <= OWN_IFU;
            last      <= OWN_LSU;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        owner   <= OWN_LSU;
                        last    <= OWN_LSU;
                        addr_q  <= lsu_addr;
                        wen_q   <= lsu_wen;
                        wdata_q <= lsu_wdata;
                        wmask_q <= lsu_wmask;
                        cnt     <= CNT_INIT;
                        state   <= ST_WAIT;
                    end else if (gnt[0]) begin
                        // Fetches are always reads with no write payload.
                        owner   <= OWN_IFU;
                        last    <= OWN_IFU;
                        addr_q  <= ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        cnt     <= CNT_INIT;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        // Only the owner's data register moves; the other
                        // side keeps its last response.
                        if (owner == OWN_LSU) begin
                            lsu_rdata <= wen_q ? '0 : mem_rdata;
                        end else begin
                            ifu_rdata <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Bench for the memory-port arbiter. Instance a uses MEM_LAT=1 and is driven
// from a per-cycle vector table; instance b uses MEM_LAT=3 for the
// multi-cycle latency and reset-abort sequences.
module tb_ysyx_24100005_mem_arbiter;

    localparam logic [31:0] IA = 32'h8000_0000;
    localparam logic [31:0] I4 = 32'h8000_0004;
    localparam logic [31:0] I8 = 32'h8000_0008;
    localparam logic [31:0] IC = 32'h8000_000C;
    localparam logic [31:0] LA = 32'h8000_0100;
    localparam logic [31:0] L2 = 32'h8000_0200;
    localparam logic [31:0] L4 = 32'h8000_0204;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;
    localparam logic [31:0] MD = 32'h0010_0073;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- instance a (MEM_LAT=1) ----------------
    logic        a_rst = 1'b0;
    logic        a_ifu_valid = 1'b0, a_ifu_ready, a_ifu_resp_valid;
    logic [31:0] a_ifu_addr = '0, a_ifu_rdata;
    logic        a_lsu_valid = 1'b0, a_lsu_ready, a_lsu_wen = 1'b0, a_lsu_resp_valid;
    logic [31:0] a_lsu_addr = '0, a_lsu_wdata = '0, a_lsu_rdata;
    logic [3:0]  a_lsu_wmask = '0, a_mem_wmask;
    logic        a_mem_valid, a_mem_wen;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata = '0;
    logic [1:0]  a_dbg_state;

    ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .ifu_valid(a_ifu_valid), .ifu_ready(a_ifu_ready), .ifu_addr(a_ifu_addr),
        .ifu_resp_valid(a_ifu_resp_valid), .ifu_rdata(a_ifu_rdata),
        .lsu_valid(a_lsu_valid), .lsu_ready(a_lsu_ready), .lsu_addr(a_lsu_addr),
        .lsu_wen(a_lsu_wen), .lsu_wdata(a_lsu_wdata), .lsu_wmask(a_lsu_wmask),
        .lsu_resp_valid(a_lsu_resp_valid), .lsu_rdata(a_lsu_rdata),
        .mem_valid(a_mem_valid), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata),
        .dbg_state(a_dbg_state)
    );

    // ---------------- instance b (MEM_LAT=3) ----------------
    logic        b_rst = 1'b0;
    logic        b_ifu_valid = 1'b0, b_ifu_ready, b_ifu_resp_valid;
    logic [31:0] b_ifu_addr = '0, b_ifu_rdata;
    logic        b_lsu_valid = 1'b0, b_lsu_ready, b_lsu_wen = 1'b0, b_lsu_resp_valid;
    logic [31:0] b_lsu_addr = '0, b_lsu_wdata = '0, b_lsu_rdata;
    logic [3:0]  b_lsu_wmask = '0, b_mem_wmask;
    logic        b_mem_valid, b_mem_wen;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata = '0;
    logic [1:0]  b_dbg_state;

    ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .ifu_valid(b_ifu_valid), .ifu_ready(b_ifu_ready), .ifu_addr(b_ifu_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_rdata(b_ifu_rdata),
        .lsu_valid(b_lsu_valid), .lsu_ready(b_lsu_ready), .lsu_addr(b_lsu_addr),
        .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata), .lsu_wmask(b_lsu_wmask),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_rdata(b_lsu_rdata),
        .mem_valid(b_mem_valid), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata),
        .dbg_state(b_dbg_state)
    );

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        lw;
        logic [31:0] lwd;
        logic [3:0]  lm;
        logic [31:0] mrd;
        logic        e_ir;
        logic        e_lr;
        logic        e_mv;
        logic        e_mw;
        logic        cm;     // compare memory address/data/mask this row
        logic [31:0] e_ma;
        logic [31:0] e_mwd;
        logic [3:0]  e_mm;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_lrv;
        logic [31:0] e_lrd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic rst, input logic iv, input logic [31:0] ia,
        input logic lv, input logic [31:0] la, input logic lw,
        input logic [31:0] lwd, input logic [3:0] lm, input logic [31:0] mrd,
        input logic e_ir, input logic e_lr, input logic e_mv, input logic e_mw,
        input logic cm, input logic [31:0] e_ma, input logic [31:0] e_mwd,
        input logic [3:0] e_mm, input logic e_irv, input logic [31:0] e_ird,
        input logic e_lrv, input logic [31:0] e_lrd);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lw = lw;
        v.lwd = lwd; v.lm = lm; v.mrd = mrd;
        v.e_ir = e_ir; v.e_lr = e_lr; v.e_mv = e_mv; v.e_mw = e_mw; v.cm = cm;
        v.e_ma = e_ma; v.e_mwd = e_mwd; v.e_mm = e_mm;
        v.e_irv = e_irv; v.e_ird = e_ird; v.e_lrv = e_lrv; v.e_lrd = e_lrd;
        vecs.push_back(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int found;
        int mv_cnt;
        int mw_cnt;

        // rst  iv ia  lv la  lw lwd lm    mrd            | ir lr mv mw cm ma  mwd mm    irv ird            lrv lrd
        // reset held with both requesters valid
        add(0,  1, IA, 1, LA, 1, WD, 4'h3, 32'h0,           0, 0, 0, 0, 1, 0,  0,  4'h0, 0, 32'h0,          0, 32'h0);
        add(0,  1, IA, 1, LA, 1, WD, 4'h3, 32'h0,           0, 0, 0, 0, 1, 0,  0,  4'h0, 0, 32'h0,          0, 32'h0);
        // first tie after reset goes to IFU
        add(1,  1, IA, 1, LA, 1, WD, 4'h3, 32'h0,           1, 0, 0, 0, 0, 0,  0,  4'h0, 0, 32'h0,          0, 32'h0);
        add(1,  0, 0,  1, LA, 1, WD, 4'h3, MD,              0, 0, 1, 0, 1, IA, 0,  4'h0, 0, 32'h0,          0, 32'h0);
        add(1,  0, 0,  1, LA, 1, WD, 4'h3, 32'h0000_1234,   0, 0, 0, 0, 0, 0,  0,  4'h0, 1, MD,             0, 32'h0);
        // LSU write
        add(1,  0, 0,  1, LA, 1, WD, 4'h3, 32'h0,           0, 1, 0, 0, 0, 0,  0,  4'h0, 0, MD,             0, 32'h0);
        add(1,  0, 0,  0, 0,  0, 0,  4'h0, 32'hFFFF_FFFF,   0, 0, 1, 1, 1, LA, WD, 4'h3, 0, MD,             0, 32'h0);
        add(1,  0, 0,  0, 0,  0, 0,  4'h0, 32'h0,           0, 0, 0, 0, 0, 0,  0,  4'h0, 0, MD,             1, 32'h0);
        // contention: IFU, LSU, IFU, LSU
        add(1,  1, I4, 1, L2, 0, 0,  4'h0, 32'h0,           1, 0, 0, 0, 0, 0,  0,  4'h0, 0, MD,             0, 32'h0);
        add(1,  1, I8, 1, L2, 0, 0,  4'h0, 32'hAAAA_0001,   0, 0, 1, 0, 1, I4, 0,  4'h0, 0, MD,             0, 32'h0);
        add(1,  1, I8, 1, L2, 0, 0,  4'h0, 32'h0,           0, 0, 0, 0, 0, 0,  0,  4'h0, 1, 32'hAAAA_0001,  0, 32'h0);
        add(1,  1, I8, 1, L2, 0, 0,  4'h0, 32'h0,           0, 1, 0, 0, 0, 0,  0,  4'h0, 0, 32'hAAAA_0001,  0, 32'h0);
        add(1,  1, I8, 1, L4, 0, 0,  4'h0, 32'hBBBB_0002,   0, 0, 1, 0, 1, L2, 0,  4'h0, 0, 32'hAAAA_0001,  0, 32'h0);
        add(1,  1, I8, 1, L4, 0, 0,  4'h0, 32'h0,           0, 0, 0, 0, 0, 0,  0,  4'h0, 0, 32'hAAAA_0001,  1, 32'hBBBB_0002);
        add(1,  1, I8, 1, L4, 0, 0,  4'h0, 32'h0,           1, 0, 0, 0, 0, 0,  0,  4'h0, 0, 32'hAAAA_0001,  0, 32'hBBBB_0002);
        add(1,  1, IC, 1, L4, 0, 0,  4'h0, 32'hCCCC_0003,   0, 0, 1, 0, 1, I8, 0,  4'h0, 0, 32'hAAAA_0001,  0, 32'hBBBB_0002);
        add(1,  1, IC, 1, L4, 0, 0,  4'h0, 32'h0,           0, 0, 0, 0, 0, 0,  0,  4'h0, 1, 32'hCCCC_0003,  0, 32'hBBBB_0002);
        add(1,  1, IC, 1, L4, 0, 0,  4'h0, 32'h0,           0, 1, 0, 0, 0, 0,  0,  4'h0, 0, 32'hCCCC_0003,  0, 32'hBBBB_0002);
        add(1,  0, 0,  0, 0,  0, 0,  4'h0, 32'hDDDD_0004,   0, 0, 1, 0, 1, L4, 0,  4'h0, 0, 32'hCCCC_0003,  0, 32'hBBBB_0002);
        add(1,  0, 0,  0, 0,  0, 0,  4'h0, 32'h0,           0, 0, 0, 0, 0, 0,  0,  4'h0, 0, 32'hCCCC_0003,  1, 32'hDDDD_0004);
        add(1,  0, 0,  0, 0,  0, 0,  4'h0, 32'h0,           0, 0, 0, 0, 0, 0,  0,  4'h0, 0, 32'hCCCC_0003,  0, 32'hDDDD_0004);

        // Inputs change on the falling edge; outputs are read 1 ns later.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_rst       = vecs[i].rst;
            a_ifu_valid = vecs[i].iv;
            a_ifu_addr  = vecs[i].ia;
            a_lsu_valid = vecs[i].lv;
            a_lsu_addr  = vecs[i].la;
            a_lsu_wen   = vecs[i].lw;
            a_lsu_wdata = vecs[i].lwd;
            a_lsu_wmask = vecs[i].lm;
            a_mem_rdata = vecs[i].mrd;
            #1;
            chk($sformatf("a r%0d ifu_ready", i), 32'(a_ifu_ready), 32'(vecs[i].e_ir));
            chk($sformatf("a r%0d lsu_ready", i), 32'(a_lsu_ready), 32'(vecs[i].e_lr));
            chk($sformatf("a r%0d mem_valid", i), 32'(a_mem_valid), 32'(vecs[i].e_mv));
            chk($sformatf("a r%0d mem_wen", i), 32'(a_mem_wen), 32'(vecs[i].e_mw));
            chk($sformatf("a r%0d ifu_resp_valid", i), 32'(a_ifu_resp_valid), 32'(vecs[i].e_irv));
            chk($sformatf("a r%0d ifu_rdata", i), a_ifu_rdata, vecs[i].e_ird);
            chk($sformatf("a r%0d lsu_resp_valid", i), 32'(a_lsu_resp_valid), 32'(vecs[i].e_lrv));
            chk($sformatf("a r%0d lsu_rdata", i), a_lsu_rdata, vecs[i].e_lrd);
            if (vecs[i].cm) begin
                chk($sformatf("a r%0d mem_addr", i), a_mem_addr, vecs[i].e_ma);
                chk($sformatf("a r%0d mem_wdata", i), a_mem_wdata, vecs[i].e_mwd);
                chk($sformatf("a r%0d mem_wmask", i), 32'(a_mem_wmask), 32'(vecs[i].e_mm));
            end
            if (vecs[i].rst == 1'b0) begin
                chk($sformatf("a r%0d state", i), 32'(a_dbg_state), 32'd0);
            end
        end

        // ---- MEM_LAT=3: LSU read, latency and throughput ----
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_lsu_valid = 1'b1; b_lsu_addr = 32'h8000_0300; b_lsu_wen = 1'b0;
        b_lsu_wdata = '0; b_lsu_wmask = '0;
        #1 chk("b T0 lsu_ready", 32'(b_lsu_ready), 32'd1);
        chk("b T0 mem_valid", 32'(b_mem_valid), 32'd0);
        // Requester immediately presents a second request that must wait.
        @(negedge clk); b_mem_rdata = 32'h0000_0011;
        #1 chk("b T1 mem_valid", 32'(b_mem_valid), 32'd1);
        chk("b T1 mem_wen", 32'(b_mem_wen), 32'd0);
        chk("b T1 mem_addr", b_mem_addr, 32'h8000_0300);
        chk("b T1 lsu_ready", 32'(b_lsu_ready), 32'd0);
        @(negedge clk); b_mem_rdata = 32'h0000_0022;
        #1 chk("b T2 mem_valid", 32'(b_mem_valid), 32'd1);
        chk("b T2 mem_wen", 32'(b_mem_wen), 32'd0);
        chk("b T2 lsu_ready", 32'(b_lsu_ready), 32'd0);
        @(negedge clk); b_mem_rdata = 32'h0000_0033;
        #1 chk("b T3 mem_valid", 32'(b_mem_valid), 32'd1);
        chk("b T3 mem_wen", 32'(b_mem_wen), 32'd0);
        chk("b T3 lsu_resp_valid", 32'(b_lsu_resp_valid), 32'd0);
        @(negedge clk); b_mem_rdata = 32'h0000_0044;
        #1 chk("b T4 mem_valid", 32'(b_mem_valid), 32'd0);
        chk("b T4 lsu_resp_valid", 32'(b_lsu_resp_valid), 32'd1);
        chk("b T4 lsu_rdata", b_lsu_rdata, 32'h0000_0033);
        chk("b T4 lsu_ready", 32'(b_lsu_ready), 32'd0);
        chk("b T4 ifu_resp_valid", 32'(b_ifu_resp_valid), 32'd0);
        @(negedge clk);
        #1 chk("b T5 lsu_ready", 32'(b_lsu_ready), 32'd1);
        chk("b T5 lsu_resp_valid", 32'(b_lsu_resp_valid), 32'd0);
        // Second read runs T6..T8 and responds at T9.
        @(negedge clk); b_lsu_valid = 1'b0; b_mem_rdata = 32'h0000_0055;
        repeat (3) @(negedge clk);
        #1 chk("b T9 lsu_resp_valid", 32'(b_lsu_resp_valid), 32'd1);
        chk("b T9 lsu_rdata", b_lsu_rdata, 32'h0000_0055);
        @(negedge clk);
        #1 chk("b T10 state idle", 32'(b_dbg_state), 32'd0);

        // ---- MEM_LAT=3: reset during WAIT of a write ----
        @(negedge clk);
        b_lsu_valid = 1'b1; b_lsu_addr = 32'h8000_0400; b_lsu_wen = 1'b1;
        b_lsu_wdata = 32'h1234_5678; b_lsu_wmask = 4'hF;
        #1 chk("b abort T0 lsu_ready", 32'(b_lsu_ready), 32'd1);
        @(negedge clk); b_lsu_valid = 1'b0; b_lsu_wen = 1'b0;
        #1 chk("b abort T1 mem_valid", 32'(b_mem_valid), 32'd1);
        chk("b abort T1 mem_wen", 32'(b_mem_wen), 32'd0);
        @(negedge clk);
        #1 chk("b abort T2 mem_wen", 32'(b_mem_wen), 32'd0);
        b_rst = 1'b0;
        #1 chk("b abort rst mem_valid", 32'(b_mem_valid), 32'd0);
        chk("b abort rst mem_addr", b_mem_addr, 32'h0);
        chk("b abort rst lsu_rdata", b_lsu_rdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk($sformatf("b abort hold%0d mem_wen", c), 32'(b_mem_wen), 32'd0);
            chk($sformatf("b abort hold%0d lsu_resp_valid", c), 32'(b_lsu_resp_valid), 32'd0);
        end
        b_rst = 1'b1;

        // Fresh IFU read completes normally after the abort.
        @(negedge clk);
        b_ifu_valid = 1'b1; b_ifu_addr = IA; b_mem_rdata = MD;
        #1 chk("b fresh ifu_ready", 32'(b_ifu_ready), 32'd1);
        found = 0; mv_cnt = 0; mw_cnt = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            @(negedge clk);
            b_ifu_valid = 1'b0;
            #1;
            if (b_mem_valid) mv_cnt++;
            if (b_mem_wen) mw_cnt++;
            if (b_ifu_resp_valid) begin
                found = 1;
                chk("b fresh ifu_rdata", b_ifu_rdata, MD);
            end
        end
        chk("b fresh resp seen", 32'(found), 32'd1);
        chk("b fresh mem_valid cycles", 32'(mv_cnt), 32'd3);
        chk("b fresh mem_wen cycles", 32'(mw_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
# ysyx_24100005_mem_arbiter

Two-requester arbiter and sequencer for the single NPC memory port, which the DPI accessors `npcmem_read` and `npcmem_write` sit behind. It shares the port between instruction fetch (IFU) and load/store (LSU). It accepts one request at a time over a valid/ready handshake, drives the memory port for a fixed latency, and returns a one-cycle response to the winning requester. It sits between the core's fetch/LSU logic in `ysyx_24100005_top` and the memory-access wrapper.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte mask width is `DATA_W/8`
- `MEM_LAT`, 1, number of cycles the memory port is held per access; legal range 1..15

Ports (reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ifu_valid`  in  1  IFU request pending
- `ifu_ready`  out  1  IFU request accepted this cycle
- `ifu_addr`  in  ADDR_W  IFU address (always a read)
- `ifu_resp_valid`  out  1  IFU response strobe
- `ifu_rdata`  out  DATA_W  IFU read data
- `lsu_valid`  in  1  LSU request pending
- `lsu_ready`  out  1  LSU request accepted this cycle
- `lsu_addr`  in  ADDR_W  LSU address
- `lsu_wen`  in  1  1 = write, 0 = read
- `lsu_wdata`  in  DATA_W  write data
- `lsu_wmask`  in  DATA_W/8  write byte mask
- `lsu_resp_valid`  out  1  LSU response strobe (read data or write ack)
- `lsu_rdata`  out  DATA_W  LSU read data; 0 for writes
- `mem_valid`  out  1  memory read enable
- `mem_wen`  out  1  memory write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_wmask`  out  DATA_W/8  memory write mask
- `mem_rdata`  in  DATA_W  memory read data, combinational from the port

## Operation
The controller is a three-state FSM.

- **IDLE**
  - If any `*_valid` is high, pick a winner and assert that requester's `*_ready` combinationally in the same cycle.
  - Latch the winner's `addr`, `wen`, `wdata`, `wmask` and owner id, load `cnt = MEM_LAT-1`, and go to WAIT.
  - IFU requests latch `wen = 0`.
- **WAIT**
  - `mem_valid = 1` and `mem_addr`/`mem_wdata`/`mem_wmask` are driven from the latched fields.
  - `mem_wen = latched wen`, asserted only in the final WAIT cycle (`cnt == 0`), so each write executes exactly once.
  - Decrement `cnt` each cycle.
  - When `cnt == 0`: capture `mem_rdata` into the response register (or 0 for a write) and go to RESP.
- **RESP**
  - The owner's `*_resp_valid = 1` for exactly one cycle, with `*_rdata` driven from the response register. Go to IDLE.
  - Requesters must accept the response; there is no backpressure.

Arbitration:
- Round-robin with a `last` register. When both requesters are valid, the one not in `last` wins.
- A single valid requester always wins.
- `last` updates on every grant. Reset value of `last` is LSU, so IFU wins the first tie.

Other rules:
- `*_ready` is 0 in WAIT and RESP. A requester holds `valid` and its payload stable until `ready`.
- The non-owner's `resp_valid` is always 0. The non-owner's `rdata` holds its last value.

## Timing
- Handshake cycle T0 is in IDLE. `mem_valid` is high for T1..T`MEM_LAT`. `resp_valid` is high at T`MEM_LAT+1`. Back in IDLE at T`MEM_LAT+2`.
- Throughput is one access per `MEM_LAT+2` cycles. With `MEM_LAT=1`: handshake, mem, resp, then the next handshake on the 4th cycle.
- Reset values: state IDLE, all `*_ready`, `*_resp_valid`, `mem_valid` and `mem_wen` = 0; all data/addr outputs 0; `last` = LSU.
- Reset asserted mid-transaction aborts it immediately. No response is issued, and no write occurs if reset lands before the final WAIT cycle.
- A `valid` that arrives while the block is busy waits; it is serviced at the next IDLE cycle.
- `valid` deasserted before `ready` is legal (request withdrawn) and produces no grant.

## Structure
- Package `ysyx_24100005_mem_pkg` holds:
  - state encoding: `ST_IDLE`, `ST_WAIT`, `ST_RESP`
  - owner-id constants: `OWN_IFU = 0`, `OWN_LSU = 1`
- Sub-module `ysyx_24100005_rr_arb2` is a combinational 2-way round-robin picker: inputs `req[1:0]` and `last`; outputs a one-hot `gnt`.
- Everything else (FSM, counter, latches, response register) lives in the top of the block.

## Test plan
- **Reset:** hold `rst=0` with both valids high → all outputs 0. Release → IFU is granted first (`ifu_ready=1`, `lsu_ready=0`).
- **IFU read, `MEM_LAT=1`:** `ifu_addr=0x8000_0000`, memory returns `0x0010_0073` → `mem_valid` high exactly one cycle; `ifu_resp_valid` two cycles after the handshake with `ifu_rdata=0x0010_0073`.
- **LSU write:** `addr=0x8000_0100`, `wdata=0xDEAD_BEEF`, `wmask=4'b0011` → `mem_wen` high exactly one cycle with those values; `lsu_resp_valid` pulses with `lsu_rdata=0`.
- **Contention:** both valid continuously for 4 transactions → grants alternate IFU, LSU, IFU, LSU; each response goes only to its owner.
- **`MEM_LAT=3`:** LSU read → `mem_valid` held 3 cycles, `mem_wen` never high, `mem_rdata` sampled in the 3rd cycle, response at T4; the next `ready` is not before T5.
- **Abort:** assert `rst` during WAIT of an LSU write with `MEM_LAT=3` → no `mem_wen`, no `resp_valid`; after release, a fresh request completes normally.
